viterbi_stream_decoder: RTL and testbench

- Parametrised successor to the team's fixed 3-state HMM Viterbi block. It handles generic state and symbol counts, runtime-loadable model tables, and a valid/ready observation stream.
- The decoded path leaves as a backpressured stream instead of parallel pins.
- Sits between the observation front-end (symbol FIFO) and the path consumer/scoreboard in the HMM inference datapath.

---
 rtl/viterbi_pkg.sv | 40 ++++
 rtl/viterbi_acs.sv | 33 +++
 rtl/viterbi_stream_decoder.sv | 249 ++++++++++++++++++++++++
 tb/tb_viterbi_stream_decoder.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared types and saturating arithmetic for the streaming Viterbi decoder.
package viterbi_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FWD  = 3'd1,
        TERM = 3'd2,
        BACK = 3'd3,
        OUT  = 3'd4
    } state_t;

    localparam logic [1:0] CFG_A = 2'd0;
    localparam logic [1:0] CFG_B = 2'd1;
    localparam logic [1:0] CFG_C = 2'd2;

    localparam int unsigned DEF_W = 16;

    function automatic logic signed [31:0] sat_max(input int unsigned w);
        return 32'((longint'(1) <<< (w - 1)) - longint'(1));
    endfunction

    function automatic logic signed [31:0] sat_min(input int unsigned w);
        return 32'(-(longint'(1) <<< (w - 1)));
    endfunction

    localparam logic signed [31:0] MAX_DEF = sat_max(DEF_W);
    localparam logic signed [31:0] MIN_DEF = sat_min(DEF_W);

    // Add two sign-extended operands and clamp to the signed w-bit range.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int unsigned w);
        longint s;
        s = longint'(a) + longint'(b);
        if (s > longint'(sat_max(w))) return sat_max(w);
        if (s < longint'(sat_min(w))) return sat_min(w);
        return 32'(s);
    endfunction

endpackage

// File: rtl/viterbi_acs.sv
// Combinational add-compare-select for one destination state; lowest source index wins ties.
module viterbi_acs
    import viterbi_pkg::*;
#(
    parameter int unsigned NS = 3,
    parameter int unsigned W  = 16,
    parameter int unsigned SW = $clog2(NS)
) (
    input  logic signed [W-1:0] delta [NS],
    input  logic signed [W-1:0] a_col [NS],
    input  logic signed [W-1:0] emit,
    output logic signed [W-1:0] delta_new,
    output logic        [SW-1:0] psi
);

    logic signed [W-1:0] best;
    logic signed [W-1:0] cand;

    always_comb begin
        cand = '0;
        best = W'(sat_add(32'(delta[0]), 32'(a_col[0]), W));
        psi  = '0;
        for (int i = 1; i < NS; i++) begin
            cand = W'(sat_add(32'(delta[i]), 32'(a_col[i]), W));
            if (cand > best) begin
                best = cand;
                psi  = SW'(i);
            end
        end
        delta_new = W'(sat_add(32'(best), 32'(emit), W));
    end

endmodule

// File: rtl/viterbi_stream_decoder.sv
// Streaming HMM Viterbi decoder: loadable tables, valid/ready observations, backpressured path output.
// Define VITERBI_NORM_EN to renormalise deltas each step and report the accumulated offset as best_score.
module viterbi_stream_decoder
    import viterbi_pkg::*;
#(
    parameter  int unsigned NS      = 3,
    parameter  int unsigned NK      = 3,
    parameter  int unsigned MAX_LEN = 16,
    parameter  int unsigned W       = 16,
    localparam int unsigned AW      = $clog2(NS * ((NS > NK) ? NS : NK)),
    localparam int unsigned LW      = $clog2(MAX_LEN + 1),
    localparam int unsigned KW      = $clog2(NK),
    localparam int unsigned SW      = $clog2(NS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_we,
    input  logic [1:0]          cfg_sel,
    input  logic [AW-1:0]       cfg_addr,
    input  logic signed [W-1:0] cfg_data,
    input  logic                start,
    input  logic [LW-1:0]       seq_len,
    input  logic                obs_valid,
    input  logic [KW-1:0]       obs_sym,
    output logic                obs_ready,
    output logic                path_valid,
    output logic [SW-1:0]       path_state,
    output logic                path_last,
    input  logic                path_ready,
    output logic signed [W-1:0] best_score,
    output logic                busy,
    output logic                err
);

    localparam int unsigned IW = $clog2(MAX_LEN);
    localparam int unsigned NA = NS * NS;
    localparam int unsigned NB = NS * NK;

    state_t state;

    logic signed [W-1:0] tab_a [NA];
    logic signed [W-1:0] tab_b [NB];
    logic signed [W-1:0] tab_c [NS];

    logic signed [W-1:0] delta      [NS];
    logic signed [W-1:0] emit       [NS];
    logic signed [W-1:0] init       [NS];
    logic signed [W-1:0] acs_out    [NS];
    logic signed [W-1:0] step_delta [NS];
    logic        [SW-1:0] acs_psi   [NS];

    logic [SW-1:0] psi_mem  [MAX_LEN][NS];
    logic [SW-1:0] path_mem [MAX_LEN];

    logic [LW-1:0] len;
    logic [LW-1:0] t;
    logic [LW-1:0] idx;
    logic [SW-1:0] cur;
    logic [KW-1:0] sym;

    logic signed [W-1:0] dmax;
    logic [SW-1:0]       darg;

`ifdef VITERBI_NORM_EN
    logic signed [W-1:0] offset;
`endif

    // Out-of-alphabet symbols decode as symbol 0.
    assign sym = (32'(obs_sym) >= NK) ? '0 : obs_sym;

    // Emission column for the current symbol and the t=0 initial deltas.
    always_comb begin
        for (int j = 0; j < NS; j++) begin
            emit[j] = tab_b[j * NK];
            for (int k = 1; k < NK; k++) begin
                if (int'(sym) == k) emit[j] = tab_b[j * NK + k];
            end
            init[j] = W'(sat_add(32'(tab_c[j]), 32'(emit[j]), W));
        end
    end

    for (genvar j = 0; j < NS; j++) begin : g_acs
        logic signed [W-1:0] col [NS];

        always_comb begin
            for (int i = 0; i < NS; i++) col[i] = tab_a[i * NS + j];
        end

        viterbi_acs #(
            .NS (NS),
            .W  (W),
            .SW (SW)
        ) u_acs (
            .delta     (delta),
            .a_col     (col),
            .emit      (emit[j]),
            .delta_new (acs_out[j]),
            .psi       (acs_psi[j])
        );
    end

    // Max and argmax of the current deltas, lowest index on tie.
    always_comb begin
        dmax = delta[0];
        darg = '0;
        for (int i = 1; i < NS; i++) begin
            if (delta[i] > dmax) begin
                dmax = delta[i];
                darg = SW'(i);
            end
        end
    end

    always_comb begin
        for (int j = 0; j < NS; j++) begin
`ifdef VITERBI_NORM_EN
            step_delta[j] = W'(sat_add(32'(acs_out[j]), -(32'(dmax)), W));
`else
            step_delta[j] = acs_out[j];
`endif
        end
    end

    // Model tables: writable only while idle, out-of-range addresses dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NA; k++) tab_a[k] <= '0;
            for (int k = 0; k < NB; k++) tab_b[k] <= '0;
            for (int k = 0; k < NS; k++) tab_c[k] <= '0;
        end else if (cfg_we && state == IDLE) begin
            case (cfg_sel)
                CFG_A: for (int k = 0; k < NA; k++) if (int'(cfg_addr) == k) tab_a[k] <= cfg_data;
                CFG_B: for (int k = 0; k < NB; k++) if (int'(cfg_addr) == k) tab_b[k] <= cfg_data;
                CFG_C: for (int k = 0; k < NS; k++) if (int'(cfg_addr) == k) tab_c[k] <= cfg_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            len        <= '0;
            t          <= '0;
            idx        <= '0;
            cur        <= '0;
            obs_ready  <= 1'b0;
            path_valid <= 1'b0;
            path_state <= '0;
            path_last  <= 1'b0;
            best_score <= '0;
            busy       <= 1'b0;
            err        <= 1'b0;
`ifdef VITERBI_NORM_EN
            offset     <= '0;
`endif
            for (int j = 0; j < NS; j++) delta[j] <= '0;
            for (int s = 0; s < MAX_LEN; s++) begin
                path_mem[s] <= '0;
                for (int j = 0; j < NS; j++) psi_mem[s][j] <= '0;
            end
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (seq_len != '0 && 32'(seq_len) <= MAX_LEN) begin
                            len       <= seq_len;
                            t         <= '0;
                            obs_ready <= 1'b1;
                            busy      <= 1'b1;
`ifdef VITERBI_NORM_EN
                            offset    <= '0;
`endif
                            state     <= FWD;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end

                FWD: begin
                    if (obs_valid) begin
                        if (t == '0) begin
                            for (int j = 0; j < NS; j++) delta[j] <= init[j];
                        end else begin
                            for (int j = 0; j < NS; j++) begin
                                delta[j]                <= step_delta[j];
                                psi_mem[t[IW-1:0]][j]   <= acs_psi[j];
                            end
`ifdef VITERBI_NORM_EN
                            offset <= W'(sat_add(32'(offset), 32'(dmax), W));
`endif
                        end
                        t <= t + 1'b1;
                        if (t + 1'b1 == len) begin
                            obs_ready <= 1'b0;
                            state     <= TERM;
                        end
                    end
                end

                TERM: begin
`ifdef VITERBI_NORM_EN
                    best_score <= W'(sat_add(32'(offset), 32'(dmax), W));
`else
                    best_score <= dmax;
`endif
                    path_mem[IW'(len - 1'b1)] <= darg;
                    cur   <= darg;
                    t     <= len - 1'b1;
                    idx   <= '0;
                    state <= (len == LW'(1)) ? OUT : BACK;
                end

                // Walk the survivor pointers from the final state back to t=0.
                BACK: begin
                    path_mem[IW'(t - 1'b1)] <= psi_mem[t[IW-1:0]][cur];
                    cur <= psi_mem[t[IW-1:0]][cur];
                    t   <= t - 1'b1;
                    if (t == LW'(1)) state <= OUT;
                end

                OUT: begin
                    if (!path_valid) begin
                        path_valid <= 1'b1;
                        path_state <= path_mem[idx[IW-1:0]];
                        path_last  <= (idx == len - 1'b1);
                    end else if (path_ready) begin
                        if (path_last) begin
                            path_valid <= 1'b0;
                            path_last  <= 1'b0;
                            path_state <= '0;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            idx        <= idx + 1'b1;
                            path_state <= path_mem[IW'(idx + 1'b1)];
                            path_last  <= (idx + 1'b1 == len - 1'b1);
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_viterbi_stream_decoder.sv
// Directed bench for viterbi_stream_decoder with a reference Viterbi model and a streaming path checker.
module tb_viterbi_stream_decoder;

    localparam int NS = 3;
    localparam int NK = 3;
    localparam int ML = 16;
    localparam int W  = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cfg_we;
    logic [1:0]         cfg_sel;
    logic [3:0]         cfg_addr;
    logic signed [15:0] cfg_data;
    logic               start;
    logic [4:0]         seq_len;
    logic               obs_valid;
    logic [1:0]         obs_sym;
    logic               obs_ready;
    logic               path_valid;
    logic [1:0]         path_state;
    logic               path_last;
    logic               path_ready;
    logic signed [15:0] best_score;
    logic               busy;
    logic               err;

    viterbi_stream_decoder #(
        .NS      (NS),
        .NK      (NK),
        .MAX_LEN (ML),
        .W       (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_sel    (cfg_sel),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .start      (start),
        .seq_len    (seq_len),
        .obs_valid  (obs_valid),
        .obs_sym    (obs_sym),
        .obs_ready  (obs_ready),
        .path_valid (path_valid),
        .path_state (path_state),
        .path_last  (path_last),
        .path_ready (path_ready),
        .best_score (best_score),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int ma [3][3];
    int mb [3][3];
    int mc [3];
    int stim [16];
    int m_path [16];
    int m_score;

    int exp_q [$];
    bit stall_pending = 1'b0;
    int stall_val;
    int e_val;

    task automatic chk(input string name, input longint act, input longint expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
        end
    endtask

    function automatic int clampw(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    // Textbook Viterbi over the bench's copy of the tables.
    function automatic void model(input int len);
        int d [3];
        int nd [3];
        int psi [16][3];
        int s, best, arg, c, fin;
        for (int t = 0; t < len; t++) begin
            s = (stim[t] >= NK) ? 0 : stim[t];
            if (t == 0) begin
                for (int j = 0; j < NS; j++) d[j] = clampw(mc[j] + mb[j][s]);
            end else begin
                for (int j = 0; j < NS; j++) begin
                    best = clampw(d[0] + ma[0][j]);
                    arg  = 0;
                    for (int i = 1; i < NS; i++) begin
                        c = clampw(d[i] + ma[i][j]);
                        if (c > best) begin
                            best = c;
                            arg  = i;
                        end
                    end
                    nd[j]     = clampw(best + mb[j][s]);
                    psi[t][j] = arg;
                end
                d = nd;
            end
        end
        m_score = d[0];
        fin     = 0;
        for (int i = 1; i < NS; i++) begin
            if (d[i] > m_score) begin
                m_score = d[i];
                fin     = i;
            end
        end
        m_path[len-1] = fin;
        for (int t = len - 1; t >= 1; t--) m_path[t-1] = psi[t][m_path[t]];
    endfunction

    // Path stream checker: every accepted element against the expected queue, stalls must hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_pending = 1'b0;
        end else if (path_valid) begin
            if (stall_pending) chk("stall_hold", path_state, stall_val);
            if (path_ready) begin
                stall_pending = 1'b0;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_elem actual=%0d expected=none", path_state);
                end else begin
                    e_val = exp_q.pop_front();
                    chk("path_state", path_state, e_val);
                    chk("path_last", path_last, exp_q.size() == 0);
                end
            end else begin
                stall_pending = 1'b1;
                stall_val     = path_state;
            end
        end else if (stall_pending) begin
            stall_pending = 1'b0;
            chk("valid_dropped", path_valid, 1);
        end
    end

    task automatic cfg_write(input int sel, input int addr, input int data, input bit upd);
        cfg_we   = 1'b1;
        cfg_sel  = 2'(sel);
        cfg_addr = 4'(addr);
        cfg_data = 16'(data);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        if (upd) begin
            if (sel == 0) ma[addr/3][addr%3] = data;
            if (sel == 1) mb[addr/3][addr%3] = data;
            if (sel == 2) mc[addr] = data;
        end
    endtask

    task automatic load_diag();
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                cfg_write(0, i*3+j, (i == j) ? 0 : -8, 1'b1);
                cfg_write(1, i*3+j, (i == j) ? 0 : -16, 1'b1);
            end
            cfg_write(2, i, 0, 1'b1);
        end
    endtask

    task automatic load_zero();
        for (int k = 0; k < 9; k++) begin
            cfg_write(0, k, 0, 1'b1);
            cfg_write(1, k, 0, 1'b1);
        end
        for (int k = 0; k < 3; k++) cfg_write(2, k, 0, 1'b1);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 3; i++) begin
            mc[i] = 0;
            for (int j = 0; j < 3; j++) begin
                ma[i][j] = 0;
                mb[i][j] = 0;
            end
        end
    endtask

    task automatic run_seq(input int len, input bit gaps, input bit toggle, input bit poke);
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int consumed = 0;
        int cyc = 0;
        int lat = 0;
        model(len);
        exp_q.delete();
        for (int i = 0; i < len; i++) exp_q.push_back(m_path[i]);
        path_ready = 1'b1;
        start   = 1'b1;
        seq_len = 5'(len);
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_on", busy, 1);
        chk("obs_ready_on", obs_ready, 1);
        if (poke) begin
            cfg_we   = 1'b1;
            cfg_sel  = 2'd0;
            cfg_addr = 4'd0;
            cfg_data = -16'sd1000;
        end
        while (consumed < len && cyc < 200) begin
            obs_valid = gaps ? (cyc % 3 != 1) : 1'b1;
            obs_sym   = 2'(stim[consumed]);
            @(negedge clk);
            if (obs_valid && obs_ready) consumed++;
            @(posedge clk); #1;
            cfg_we = 1'b0;
            cyc++;
        end
        obs_valid = 1'b0;
        chk("obs_count", consumed, len);
        while (!path_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, len + 1);
        cyc = 0;
        while (busy && cyc < 400) begin
            path_ready = toggle ? pat[cyc % 4] : 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        path_ready = 1'b1;
        chk("busy_off", busy, 0);
        chk("obs_ready_off", obs_ready, 0);
        chk("elems_left", exp_q.size(), 0);
        chk("best_score", best_score, m_score);
    endtask

    initial begin
        int lit_a [5] = '{0, 0, 1, 1, 2};
        rst_n = 1'b0;
        cfg_we = 1'b0; cfg_sel = '0; cfg_addr = '0; cfg_data = '0;
        start = 1'b0; seq_len = '0; obs_valid = 1'b0; obs_sym = '0; path_ready = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_obs_ready", obs_ready, 0);
        chk("rst_path_valid", path_valid, 0);
        chk("rst_path_state", path_state, 0);
        chk("rst_path_last", path_last, 0);
        chk("rst_best_score", best_score, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Diagonal model, clean handshakes.
        load_diag();
        stim[0:4] = '{0, 0, 1, 1, 2};
        model(5);
        for (int i = 0; i < 5; i++) chk($sformatf("pin_diag_%0d", i), m_path[i], lit_a[i]);
        chk("pin_diag_score", m_score, -16);
        run_seq(5, 1'b0, 1'b0, 1'b0);
        chk("diag_score_lit", best_score, -16);

        // All-zero tables after ignored out-of-range and reserved writes.
        cfg_write(2, 5, -99, 1'b0);
        cfg_write(3, 0, -50, 1'b0);
        load_zero();
        stim[0:3] = '{2, 1, 0, 2};
        run_seq(4, 1'b0, 1'b0, 1'b0);
        chk("zero_score_lit", best_score, 0);

        // Diagonal again with gaps, stalls, symbol 3 aliasing to 0, and a write while busy.
        load_diag();
        stim[0:4] = '{3, 0, 1, 1, 2};
        model(5);
        for (int i = 0; i < 5; i++) chk($sformatf("pin_stall_%0d", i), m_path[i], lit_a[i]);
        run_seq(5, 1'b1, 1'b1, 1'b1);
        chk("stall_score_lit", best_score, -16);

        // Rejected starts: zero length and one past the maximum.
        for (int r = 0; r < 2; r++) begin
            start   = 1'b1;
            seq_len = (r == 0) ? 5'd0 : 5'd17;
            @(posedge clk); #1;
            start = 1'b0;
            chk($sformatf("err_pulse_%0d", r), err, 1);
            chk($sformatf("err_busy_%0d", r), busy, 0);
            @(posedge clk); #1;
            chk($sformatf("err_clear_%0d", r), err, 0);
        end

        // Single-element sequence.
        stim[0] = 2;
        model(1);
        chk("pin_len1_state", m_path[0], 2);
        run_seq(1, 1'b0, 1'b0, 1'b0);
        chk("len1_score_lit", best_score, 0);

        // Saturation at the negative rail.
        load_zero();
        cfg_write(2, 0, -32768, 1'b1);
        for (int k = 0; k < 9; k++) cfg_write(1, k, -32768, 1'b1);
        stim[0:2] = '{0, 1, 2};
        run_seq(3, 1'b0, 1'b0, 1'b0);
        chk("sat_score_lit", best_score, -32768);

        // Reset during the forward pass at t=2.
        load_diag();
        start   = 1'b1;
        seq_len = 5'd5;
        @(posedge clk); #1;
        start     = 1'b0;
        obs_valid = 1'b1;
        obs_sym   = 2'd0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        obs_valid = 1'b0;
        chk("mid_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_obs_ready", obs_ready, 0);
        chk("abort_path_valid", path_valid, 0);
        chk("abort_busy", busy, 0);
        exp_q.delete();
        clear_model();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        stim[0:3] = '{0, 0, 1, 1};
        run_seq(4, 1'b0, 1'b0, 1'b0);
        load_diag();
        stim[0:4] = '{0, 0, 1, 1, 2};
        run_seq(5, 1'b0, 1'b0, 1'b0);
        chk("post_reset_score_lit", best_score, -16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
